// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t CHECK = 2'd1;
    localparam state_t ADD   = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;

    // Entry 9 first so that SEG_TABLE[d] selects the pattern for digit d.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, SEG_ONE,    7'b1000000
    };

    // One decimal digit step: returns {carry_out, digit}.
    function automatic logic [4:0] bcd_digit_add(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       c
    );
        logic [4:0] t;
        logic [4:0] adj;
        t   = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        adj = t + 5'd6;
        if (t > 5'd9)
            return {1'b1, adj[3:0]};
        else
            return {1'b0, t[3:0]};
    endfunction

endpackage

// File: rtl/seven_seg_dec.sv
// Single-digit BCD to active-low seven-segment decoder.
// Dash overrides blank, which overrides the digit; non-BCD codes show blank.
module seven_seg_dec
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash)
            seg = SEG_DASH;
        else if (blank)
            seg = SEG_BLANK;
        else if (digit <= 4'd9)
            seg = SEG_TABLE[digit];
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder with start/done handshake and seven-segment output.
// Define BCD_SEG_DECODE_EN to build the segment decoders; otherwise seg is tied blank.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*DIGITS-1:0]     a,
    input  logic [4*DIGITS-1:0]     b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     sum,
    output logic                    cout,
    output logic                    invalid,
    output logic [7*(DIGITS+1)-1:0] seg
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t          state_reg;
    logic [W-1:0]    a_reg, b_reg, work_reg, sum_reg;
    logic            carry_reg, bad_reg, cout_reg, invalid_reg, done_reg;
    logic [IW-1:0]   idx_reg;
    logic [DIGITS-1:0] digit_bad;
    logic [4:0]      digit_res;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_check
            assign digit_bad[gi] = (a_reg[4*gi +: 4] > 4'd9) || (b_reg[4*gi +: 4] > 4'd9);
        end
    endgenerate

    // Operands shift right each ADD cycle, so the current digit is always at [3:0].
    assign digit_res = bcd_digit_add(a_reg[3:0], b_reg[3:0], carry_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            work_reg    <= '0;
            sum_reg     <= '0;
            carry_reg   <= 1'b0;
            bad_reg     <= 1'b0;
            cout_reg    <= 1'b0;
            invalid_reg <= 1'b0;
            done_reg    <= 1'b0;
            idx_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        work_reg  <= '0;
                        bad_reg   <= 1'b0;
                        idx_reg   <= '0;
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    if (|digit_bad) begin
                        bad_reg   <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= ADD;
                    end
                end
                ADD: begin
                    // New digits enter at the top; after DIGITS steps digit 0 sits at [3:0].
                    work_reg  <= (work_reg >> 4) | (W'(digit_res[3:0]) << (W - 4));
                    a_reg     <= a_reg >> 4;
                    b_reg     <= b_reg >> 4;
                    carry_reg <= digit_res[4];
                    idx_reg   <= idx_reg + 1'b1;
                    if (idx_reg == IW'(DIGITS - 1))
                        state_reg <= DONE;
                end
                DONE: begin
                    sum_reg     <= bad_reg ? '0 : work_reg;
                    cout_reg    <= bad_reg ? 1'b0 : carry_reg;
                    invalid_reg <= bad_reg;
                    done_reg    <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy    = (state_reg == CHECK) || (state_reg == ADD);
    assign done    = done_reg;
    assign sum     = sum_reg;
    assign cout    = cout_reg;
    assign invalid = invalid_reg;

`ifdef BCD_SEG_DECODE_EN
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_seg
            seven_seg_dec u_dec (
                .digit (sum_reg[4*gi +: 4]),
                .blank (1'b0),
                .dash  (invalid_reg),
                .seg   (seg[7*gi +: 7])
            );
        end
    endgenerate

    seven_seg_dec u_carry_dec (
        .digit (4'd1),
        .blank (~cout_reg),
        .dash  (invalid_reg),
        .seg   (seg[7*DIGITS +: 7])
    );
`else
    assign seg = '1;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed cases plus random operands
// compared against a decimal-arithmetic reference model.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int SW     = 7 * (DIGITS + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          busy, done, cout, invalid;
    logic [W-1:0]  sum;
    logic [SW-1:0] seg;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] held_sum = '0;
    logic         held_cout = 1'b0;
    logic         held_inv = 1'b0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid),
        .seg     (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: operands as decimal integers, plain addition, split back into digits.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                  output logic [W-1:0] s, output logic co, output logic inv);
        longint va, vb, pw, tot;
        va = 0; vb = 0; pw = 1; inv = 1'b0; s = '0; co = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) inv = 1'b1;
            va += longint'(x[4*i +: 4]) * pw;
            vb += longint'(y[4*i +: 4]) * pw;
            pw *= 10;
        end
        if (!inv) begin
            tot = va + vb + longint'(c);
            co  = (tot >= pw);
            tot = tot % pw;
            for (int i = 0; i < DIGITS; i++) begin
                s[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end
    endfunction

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [SW-1:0] exp_seg(input logic [W-1:0] s, input logic co, input logic inv);
        logic [SW-1:0] r;
        r = '1;
`ifdef BCD_SEG_DECODE_EN
        for (int i = 0; i <= DIGITS; i++) begin
            if (inv)
                r[7*i +: 7] = 7'b0111111;
            else if (i == DIGITS)
                r[7*i +: 7] = co ? 7'b1111001 : 7'b1111111;
            else
                r[7*i +: 7] = seg_code(int'(s[4*i +: 4]));
        end
`else
        r = '1 & {SW{s[0] | ~s[0] | co | inv}};
`endif
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_sum"}, 64'(sum), 64'(held_sum));
        check({tag, "_cout"}, 64'(cout), 64'(held_cout));
        check({tag, "_invalid"}, 64'(invalid), 64'(held_inv));
        check({tag, "_seg"}, 64'(seg), 64'(exp_seg(held_sum, held_cout, held_inv)));
    endtask

    // Called at posedge+1; runs one operation and checks latency, busy width, result.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input string tag);
        logic [W-1:0] es;
        logic eco, einv;
        int n, nb, lat_exp, busy_exp;
        bit got;
        model(x, y, c, es, eco, einv);
        lat_exp  = einv ? 3 : DIGITS + 3;
        busy_exp = einv ? 1 : DIGITS + 1;
        a = x; b = y; cin = c; start = 1'b1;
        n = 0; nb = 0; got = 0;
        while (n < 40 && !got) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'(($urandom));
            if (busy) nb++;
            if (done) got = 1;
            else if (n == 2) check({tag, "_nopartial"}, 64'(sum), 64'(held_sum));
        end
        held_sum = es; held_cout = eco; held_inv = einv;
        check({tag, "_latency"}, 64'(n), 64'(lat_exp));
        check({tag, "_busycycles"}, 64'(nb), 64'(busy_exp));
        check_outputs(tag);
        $display("op %s a=%h b=%h cin=%0d -> sum=%h cout=%0d invalid=%0d lat=%0d",
                 tag, x, y, c, sum, cout, invalid, n);
        @(posedge clk); #1;
        check({tag, "_donepulse"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n_done;
        int pos[$];
        logic [W-1:0] ra, rb;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check_outputs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h5678, 1'b0, "add_1234_5678");
        run_op(16'h9999, 16'h0001, 1'b0, "add_9999_0001");
        run_op(16'h9999, 16'h9999, 1'b1, "add_9999_9999_c");
        run_op(16'h12A4, 16'h0000, 1'b0, "invalid_12A4");
        run_op(16'h0001, 16'h0002, 1'b0, "clear_invalid");
        run_op(16'h0000, 16'h0000, 1'b1, "cin_only");

        // Start pulsed during ADD must be ignored
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        n_done = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            start = (i == 3);
            if (done) n_done++;
        end
        start = 1'b0;
        held_sum = 16'h6912; held_cout = 1'b0; held_inv = 1'b0;
        check("ignore_start_ndone", 64'(n_done), 64'd1);
        check("ignore_start_busy", 64'(busy), 64'd0);
        check_outputs("ignore_start");
        $display("op ignore_start dones=%0d sum=%h", n_done, sum);

        // Start held high through done: back-to-back operations
        a = 16'h0505; b = 16'h0505; cin = 1'b0; start = 1'b1;
        pos.delete();
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) pos.push_back(i);
            if (i == 8) start = 1'b0;
        end
        held_sum = 16'h1010; held_cout = 1'b0; held_inv = 1'b0;
        check("b2b_ndone", 64'(pos.size()), 64'd2);
        if (pos.size() == 2) begin
            check("b2b_first", 64'(pos[0]), 64'(DIGITS + 3));
            check("b2b_second", 64'(pos[1]), 64'(2 * (DIGITS + 3)));
        end
        check_outputs("b2b");
        $display("op back_to_back dones=%0d sum=%h", pos.size(), sum);

        // Reset during ADD
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        held_sum = '0; held_cout = 1'b0; held_inv = 1'b0;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check_outputs("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("midreset_nodone", 64'(n_done), 64'd0);
        check_outputs("midreset_after");
        $display("op midreset dones=%0d sum=%h", n_done, sum);
        run_op(16'h1234, 16'h5678, 1'b0, "after_reset");

        // Random operands, occasionally with a non-BCD digit
        for (int k = 0; k < 24; k++) begin
            ra = '0; rb = '0;
            for (int i = 0; i < DIGITS; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(9, 0));
                rb[4*i +: 4] = 4'($urandom_range(9, 0));
            end
            if ($urandom_range(5, 0) == 0)
                ra[4*$urandom_range(DIGITS-1, 0) +: 4] = 4'($urandom_range(15, 10));
            run_op(ra, rb, 1'($urandom_range(1, 0)), $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
